weight_rd_responder: RTL and testbench

WEIGHT_RD_RESPONDER -- requirements
Module: weight_rd_responder

---
 rtl/weight_rd_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_weight_rd_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_rd_responder.sv
// weight_rd_responder: AXI read-only slave that serves weight words from an
// internal single-port-read / single-port-write RAM. AR requests are queued in
// a small FIFO, each burst is classified once (MEM / ZERO page / ERR), beats
// are read one per cycle and presented through a 2-entry skid buffer.
module weight_rd_responder #(
    parameter int DATAWIDTH   = 64,
    parameter int ADDRWIDTH   = 32,
    parameter int LG_MEMDEPTH = 10,
    parameter int LG_ARFIFO   = 2
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_areset,
    input  logic [31:0]            ZERO_ADDR,
    input  logic                   cfg_wr_en,
    input  logic [LG_MEMDEPTH-1:0] cfg_wr_addr,
    input  logic [DATAWIDTH-1:0]   cfg_wr_data,
    input  logic [ADDRWIDTH-1:0]   s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [7:0]             s_axi_arlen,
    input  logic [2:0]             s_axi_arsize,
    input  logic [1:0]             s_axi_arburst,
    output logic [DATAWIDTH-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready
);

    localparam int MEMDEPTH = 1 << LG_MEMDEPTH;
    localparam int ARDEPTH  = 1 << LG_ARFIFO;
    localparam logic [LG_ARFIFO:0]     CNT_FULL = (LG_ARFIFO+1)'(ARDEPTH);
    localparam logic [LG_ARFIFO:0]     CNT_ONE  = (LG_ARFIFO+1)'(1);
    localparam logic [LG_ARFIFO-1:0]   PTR_ONE  = LG_ARFIFO'(1);
    localparam logic [LG_MEMDEPTH-1:0] IDX_ONE  = LG_MEMDEPTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {K_MEM, K_ZERO, K_ERR} kind_t;

    // Burst class, decided once per request; malformed requests win over the zero page
    function automatic kind_t classify(input logic [ADDRWIDTH-1:0] addr,
                                       input logic [2:0]           size,
                                       input logic [1:0]           burst,
                                       input logic [31:12]         zero_page);
        if (size != 3'b011 || burst != 2'b01 || addr[2:0] != 3'b000)
            return K_ERR;
        else if (addr[31:12] == zero_page)
            return K_ZERO;
        else
            return K_MEM;
    endfunction

    logic unused_zero_lsb;
    assign unused_zero_lsb = ^ZERO_ADDR[11:0];

    // ---------------- AR request FIFO ----------------
    logic [ADDRWIDTH-1:0] fifo_addr  [ARDEPTH];
    logic [7:0]           fifo_len   [ARDEPTH];
    logic [2:0]           fifo_size  [ARDEPTH];
    logic [1:0]           fifo_burst [ARDEPTH];
    logic [LG_ARFIFO-1:0] wr_ptr, rd_ptr;
    logic [LG_ARFIFO:0]   fifo_cnt, cnt_next;
    logic                 arready_q;
    logic                 ar_push, fifo_pop, fifo_empty;
    logic [ADDRWIDTH-1:0] head_addr;
    kind_t                head_kind;

    assign s_axi_arready = arready_q;
    assign ar_push       = s_axi_arvalid & arready_q;
    assign fifo_empty    = (fifo_cnt == '0);
    assign head_addr     = fifo_addr[rd_ptr];
    assign head_kind     = classify(head_addr, fifo_size[rd_ptr], fifo_burst[rd_ptr], ZERO_ADDR[31:12]);

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        cnt_next = fifo_cnt;
        if (ar_push && !fifo_pop)
            cnt_next = fifo_cnt + CNT_ONE;
        else if (!ar_push && fifo_pop)
            cnt_next = fifo_cnt - CNT_ONE;
    end

    // FIFO pointers, occupancy and registered arready (low throughout reset)
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            arready_q <= 1'b0;
        end else begin
            if (ar_push)  wr_ptr <= wr_ptr + PTR_ONE;
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
            fifo_cnt  <= cnt_next;
            arready_q <= (cnt_next != CNT_FULL);
        end
    end

    // FIFO storage
    always_ff @(posedge s_axis_aclk) begin
        if (ar_push) begin
            fifo_addr[wr_ptr]  <= s_axi_araddr;
            fifo_len[wr_ptr]   <= s_axi_arlen;
            fifo_size[wr_ptr]  <= s_axi_arsize;
            fifo_burst[wr_ptr] <= s_axi_arburst;
        end
    end

    // ---------------- burst sequencer / beat issue (p0) ----------------
    state_t               state;
    logic [7:0]           beat_cnt;
    logic [7:0]           cur_len;
    logic [LG_MEMDEPTH-1:0] word_idx;
    kind_t                cur_kind;
    logic                 oob_wrap;
    logic                 issue_done;

    logic                 vld_p1, zero_p1, err_p1, last_p1;
    logic [DATAWIDTH-1:0] mem_q_p1;
    logic                 out_vld_p2, out_last_p2, skid_vld_p2, skid_last_p2;
    logic [1:0]           out_resp_p2, skid_resp_p2;
    logic [DATAWIDTH-1:0] out_data_p2, skid_data_p2;

    logic       r_hs, last_hs, can_issue, issue_p0, last_p0, zero_p0, err_p0;
    logic [1:0] slots_used;

    assign r_hs       = out_vld_p2 & s_axi_rready;
    assign last_hs    = r_hs & out_last_p2;
    assign slots_used = {1'b0, out_vld_p2} + {1'b0, skid_vld_p2} + {1'b0, vld_p1};
    assign can_issue  = r_hs ? (slots_used <= 2'd2) : (slots_used <= 2'd1);
    assign issue_p0   = (state == BURST) && !issue_done && can_issue;
    assign last_p0    = (beat_cnt == cur_len);
    assign zero_p0    = (cur_kind != K_MEM) || oob_wrap;
    assign err_p0     = (cur_kind == K_ERR) || ((cur_kind == K_MEM) && oob_wrap);
    assign fifo_pop   = !fifo_empty && ((state == IDLE) || last_hs);

    // Burst FSM: load a request on pop, step the beat/word counters per issued read
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            cur_len    <= '0;
            word_idx   <= '0;
            cur_kind   <= K_MEM;
            oob_wrap   <= 1'b0;
            issue_done <= 1'b0;
        end else if (fifo_pop) begin
            state      <= BURST;
            beat_cnt   <= '0;
            cur_len    <= fifo_len[rd_ptr];
            word_idx   <= head_addr[LG_MEMDEPTH+2:3];
            cur_kind   <= head_kind;
            oob_wrap   <= 1'b0;
            issue_done <= 1'b0;
        end else begin
            if (issue_p0) begin
                beat_cnt <= beat_cnt + 8'd1;
                word_idx <= word_idx + IDX_ONE;
                // Once the index wraps, later beats lie beyond the memory window
                if (word_idx == '1) oob_wrap <= 1'b1;
                if (last_p0) issue_done <= 1'b1;
            end
            if (last_hs) state <= IDLE;
        end
    end

    // ---------------- memory read (p1) ----------------
    logic [DATAWIDTH-1:0] mem [MEMDEPTH];

    // Read-before-write RAM plus the beat attributes travelling with the read
    always_ff @(posedge s_axis_aclk) begin
        if (cfg_wr_en) mem[cfg_wr_addr] <= cfg_wr_data;
        if (issue_p0) begin
            mem_q_p1 <= mem[word_idx];
            zero_p1  <= zero_p0;
            err_p1   <= err_p0;
            last_p1  <= last_p0;
        end
    end

    // Read-in-flight flag
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) vld_p1 <= 1'b0;
        else               vld_p1 <= issue_p0;
    end

    // ---------------- skid buffer (p2) ----------------
    logic [DATAWIDTH-1:0] beat_data_p1;
    logic [1:0]           beat_resp_p1;

    assign beat_data_p1 = zero_p1 ? '0 : mem_q_p1;
    assign beat_resp_p1 = err_p1 ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_rdata  = out_data_p2;
    assign s_axi_rresp  = out_resp_p2;
    assign s_axi_rlast  = out_last_p2;
    assign s_axi_rvalid = out_vld_p2;

    // Two-entry output queue; the head register drives R and only moves on a handshake
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            out_vld_p2   <= 1'b0;
            out_data_p2  <= '0;
            out_resp_p2  <= '0;
            out_last_p2  <= 1'b0;
            skid_vld_p2  <= 1'b0;
            skid_data_p2 <= '0;
            skid_resp_p2 <= '0;
            skid_last_p2 <= 1'b0;
        end else if (r_hs) begin
            if (skid_vld_p2) begin
                out_data_p2 <= skid_data_p2;
                out_resp_p2 <= skid_resp_p2;
                out_last_p2 <= skid_last_p2;
                if (vld_p1) begin
                    skid_data_p2 <= beat_data_p1;
                    skid_resp_p2 <= beat_resp_p1;
                    skid_last_p2 <= last_p1;
                end else begin
                    skid_vld_p2 <= 1'b0;
                end
            end else if (vld_p1) begin
                out_data_p2 <= beat_data_p1;
                out_resp_p2 <= beat_resp_p1;
                out_last_p2 <= last_p1;
            end else begin
                out_vld_p2 <= 1'b0;
            end
        end else if (vld_p1) begin
            if (!out_vld_p2) begin
                out_vld_p2  <= 1'b1;
                out_data_p2 <= beat_data_p1;
                out_resp_p2 <= beat_resp_p1;
                out_last_p2 <= last_p1;
            end else begin
                skid_vld_p2  <= 1'b1;
                skid_data_p2 <= beat_data_p1;
                skid_resp_p2 <= beat_resp_p1;
                skid_last_p2 <= last_p1;
            end
        end
    end

endmodule

// File: tb/tb_weight_rd_responder.sv
// Directed plus randomized bench for weight_rd_responder with a beat-level
// reference model (expected beat queue derived from request arithmetic).
module tb_weight_rd_responder;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] zero_addr;
    logic        cfg_wr_en;
    logic [9:0]  cfg_wr_addr;
    logic [63:0] cfg_wr_data;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] model_mem [1024];
    beat_t       exp_q [$];
    int          rx_cnt = 0;
    bit          rdy_rand = 1'b0;
    bit          rdy_force = 1'b1;
    bit          stall_prev = 1'b0;
    logic [67:0] stall_snap;

    weight_rd_responder dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .ZERO_ADDR     (zero_addr),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    // rready: fixed level or random backpressure, changed away from the edge
    always @(posedge clk) begin
        #2;
        rready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one accepted request, straight from the address rules
    task automatic model_push(input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] sz, input logic [1:0] bu);
        bit err;
        bit zero;
        err  = (sz != 3'b011) || (bu != 2'b01) || (a[2:0] != 3'b000);
        zero = !err && (a[31:12] == zero_addr[31:12]);
        for (int b = 0; b <= int'(len); b++) begin
            logic [31:0] byte_a;
            beat_t t;
            byte_a = a + 32'(b) * 32'd8;
            t.last = (b == int'(len));
            if (err) begin
                t.data = '0; t.resp = 2'b10;
            end else if (zero) begin
                t.data = '0; t.resp = 2'b00;
            end else if (byte_a[31:13] != a[31:13]) begin
                t.data = '0; t.resp = 2'b10;
            end else begin
                t.data = model_mem[byte_a[12:3]]; t.resp = 2'b00;
            end
            exp_q.push_back(t);
        end
    endtask

    // Present one AR request (called #1 after an edge); bounded wait for acceptance
    task automatic send_ar(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n;
        bit done;
        araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 500) begin
            if (arready) begin
                @(posedge clk);
                model_push(a, len, sz, bu);
                done = 1'b1;
            end else begin
                @(posedge clk);
                n++;
            end
            #1;
        end
        arvalid = 1'b0;
        if (!done) check("ar_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rvalid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic first_rvalid(output int lat);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (rvalid) begin
                lat = c;
                break;
            end
        end
    endtask

    // R-channel monitor: stability under stall and in-order beat comparison
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("r_stable", {rvalid, rlast, rresp, rdata}, stall_snap);
            if (rvalid && rready) begin
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", rresp, e.resp);
                    check("rlast", rlast, e.last);
                end
                rx_cnt++;
            end
            stall_prev = rvalid && !rready;
            stall_snap = {rvalid, rlast, rresp, rdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [4:0]  pat;
        logic [63:0] d;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bu;

        rst = 1'b1; zero_addr = 32'h0001_0000;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        araddr = '0; arvalid = 1'b0; arlen = '0; arsize = '0; arburst = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 64'h0);
        rst = 1'b0;
        #1;
        check("arready_before_edge", arready, 1'b0);
        @(posedge clk); #1;
        check("arready_first_edge", arready, 1'b1);

        // Weight load: word i = i for 0..15, random above
        cfg_wr_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            d = (i < 16) ? 64'(i) : {$urandom, $urandom};
            cfg_wr_addr = 10'(i);
            cfg_wr_data = d;
            model_mem[i] = d;
            @(posedge clk); #1;
        end
        cfg_wr_en = 1'b0;

        // Basic MEM burst: latency and one beat per cycle
        rdy_force = 1'b1;
        @(posedge clk); #1;
        send_ar(32'h0, 8'd3, 3'b011, 2'b01);
        first_rvalid(lat);
        check("first_beat_latency", lat, 3);
        pat[4] = rlast;
        for (int k = 3; k >= 1; k--) begin
            @(posedge clk); #1;
            pat[k] = rvalid;
        end
        pat[0] = rlast;
        check("throughput_rlast_pattern", pat, 5'b0_111_1);
        wait_drain("mem_basic");

        // Zero page burst
        send_ar(32'h0001_0000, 8'd7, 3'b011, 2'b01);
        wait_drain("zero_page");

        // ERR burst (bad size) followed by a good MEM burst
        send_ar(32'h0000_0040, 8'd1, 3'b010, 2'b01);
        send_ar(32'h0000_0080, 8'd2, 3'b011, 2'b01);
        wait_drain("err_then_mem");

        // ERR takes precedence over the zero page (misaligned in zero page)
        send_ar(32'h0001_0001, 8'd1, 3'b011, 2'b01);
        // Single beat, FIXED burst type
        send_ar(32'h0000_0100, 8'd0, 3'b011, 2'b00);
        // Crossing the top of memory: last two beats SLVERR
        send_ar(32'h0000_1FF0, 8'd3, 3'b011, 2'b01);
        // Window above memory: index wraps, upper bits match first beat -> data
        send_ar(32'h0000_2000, 8'd1, 3'b011, 2'b01);
        wait_drain("boundaries");

        // cfg write colliding with the first read of a burst returns old data
        send_ar(32'h0000_0320, 8'd3, 3'b011, 2'b01);
        @(posedge clk); #1;
        d = 64'hDEAD_BEEF_0000_0064;
        cfg_wr_en = 1'b1; cfg_wr_addr = 10'd100; cfg_wr_data = d;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        model_mem[100] = d;
        wait_drain("collision");
        send_ar(32'h0000_0320, 8'd0, 3'b011, 2'b01);
        wait_drain("after_write");

        // Backpressure: five requests with rready low fill the FIFO
        rdy_force = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        send_ar(32'h0000_0200, 8'd1, 3'b011, 2'b01);
        send_ar(32'h0000_0300, 8'd2, 3'b011, 2'b01);
        send_ar(32'h0001_0000, 8'd0, 3'b011, 2'b01);
        send_ar(32'h0000_0400, 8'd3, 3'b011, 2'b01);
        send_ar(32'h0000_0500, 8'd1, 3'b010, 2'b01);
        check("arready_low_when_full", arready, 1'b0);
        araddr = 32'h0000_0600; arlen = 8'd2; arsize = 3'b011; arburst = 2'b01; arvalid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("arready_stays_low", arready, 1'b0);
        check("rvalid_held_in_stall", rvalid, 1'b1);
        rdy_force = 1'b1;
        send_ar(32'h0000_0600, 8'd2, 3'b011, 2'b01);
        wait_drain("backpressure");

        // Reset during beat 2 of a 16-beat burst, with another request queued
        send_ar(32'h0000_0000, 8'd15, 3'b011, 2'b01);
        send_ar(32'h0000_0100, 8'd2, 3'b011, 2'b01);
        first_rvalid(lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("reset_mid_rvalid", rvalid, 1'b0);
        check("reset_mid_arready", arready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("arready_after_midreset", arready, 1'b1);
        send_ar(32'h0000_0028, 8'd0, 3'b011, 2'b01);
        first_rvalid(lat);
        check("latency_after_reset", lat, 3);
        wait_drain("after_reset");
        repeat (20) @(posedge clk);
        #1;
        check("no_stale_beats", rvalid, 1'b0);

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            sz = 3'b011; bu = 2'b01;
            len = 8'($urandom_range(0, 15));
            a = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 1023)) << 3);
            case ($urandom_range(0, 7))
                4: a = 32'h0001_0000 | (32'($urandom_range(0, 511)) << 3);
                5: sz = 3'($urandom_range(0, 7));
                6: a = a | 32'($urandom_range(1, 7));
                7: bu = 2'($urandom_range(0, 3));
                default: ;
            endcase
            send_ar(a, len, sz, bu);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain("random");
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
